cpu_ex_stage: RTL and testbench

Execute stage of the five-stage MIPS pipeline, directly downstream of `cpu_IFID`. It holds the ID/EX register, computes the ALU result and branch target, and registers the results into the EX/MEM register. Its outputs feed the MEM stage, and its `ex_mem_pc` / `ex_mem_zero` outputs return to the fetch logic as the branch target and condition.

---
 rtl/cpu_ex_stage_pkg.sv | 89 ++++++++
 rtl/cpu_ex_stage_alu_unit.sv | 32 +++
 rtl/cpu_ex_stage.sv | 103 ++++++++++
 tb/tb_cpu_ex_stage.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ex_stage_pkg.sv
// Shared definitions for the execute stage: ALU encodings, control-field layouts
// and the pipeline register records.
package cpu_ex_stage_pkg;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10,
    ALUOP_SLT   = 2'b11
  } aluop_e;

  typedef enum logic [5:0] {
    FUNCT_ADD = 6'b100000,
    FUNCT_SUB = 6'b100010,
    FUNCT_AND = 6'b100100,
    FUNCT_OR  = 6'b100101,
    FUNCT_NOR = 6'b100111,
    FUNCT_SLT = 6'b101010
  } funct_e;

  // ALU_ZERO is the catch-all for undecodable funct codes.
  typedef enum logic [3:0] {
    ALU_AND  = 4'b0000,
    ALU_OR   = 4'b0001,
    ALU_ADD  = 4'b0010,
    ALU_SUB  = 4'b0110,
    ALU_SLT  = 4'b0111,
    ALU_NOR  = 4'b1100,
    ALU_ZERO = 4'b1111
  } alu_ctl_e;

  typedef struct packed {
    logic regwrite;
    logic memtoreg;
  } wb_t;

  typedef struct packed {
    logic branch;
    logic memread;
    logic memwrite;
  } mem_t;

  typedef struct packed {
    logic [31:0] pc_4;
    wb_t         wb;
    mem_t        mem;
    logic [1:0]  aluop;
    logic        alusrc;
    logic        regdst;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] sign_ext;
    logic [4:0]  rt_addr;
    logic [4:0]  rd_addr;
  } id_ex_t;

  typedef struct packed {
    wb_t         wb;
    mem_t        mem;
    logic [31:0] pc;
    logic        zero;
    logic [31:0] alu_result;
    logic [31:0] rdata2;
    logic [4:0]  dest;
  } ex_mem_t;

  function automatic alu_ctl_e alu_ctl_decode(input logic [1:0] aluop, input logic [5:0] funct);
    alu_ctl_e ctl;
    ctl = ALU_ZERO;
    case (aluop)
      ALUOP_ADD: ctl = ALU_ADD;
      ALUOP_SUB: ctl = ALU_SUB;
      ALUOP_SLT: ctl = ALU_SLT;
      default: begin
        case (funct)
          FUNCT_ADD: ctl = ALU_ADD;
          FUNCT_SUB: ctl = ALU_SUB;
          FUNCT_AND: ctl = ALU_AND;
          FUNCT_OR:  ctl = ALU_OR;
          FUNCT_NOR: ctl = ALU_NOR;
          FUNCT_SLT: ctl = ALU_SLT;
          default:   ctl = ALU_ZERO;
        endcase
      end
    endcase
    return ctl;
  endfunction

endpackage

// File: rtl/cpu_ex_stage_alu_unit.sv
// ALU control decode plus the combinational 32-bit ALU.
module alu_unit
  import cpu_ex_stage_pkg::*;
(
  input  logic [1:0]  i_aluop,
  input  logic [5:0]  i_funct,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [31:0] o_result,
  output logic        o_zero
);

  alu_ctl_e w_ctl;

  assign w_ctl = alu_ctl_decode(i_aluop, i_funct);

  always_comb begin
    o_result = '0;
    case (w_ctl)
      ALU_AND: o_result = i_a & i_b;
      ALU_OR:  o_result = i_a | i_b;
      ALU_ADD: o_result = i_a + i_b;
      ALU_SUB: o_result = i_a - i_b;
      ALU_SLT: o_result = {31'b0, ($signed(i_a) < $signed(i_b))};
      ALU_NOR: o_result = ~(i_a | i_b);
      default: o_result = '0;
    endcase
  end

  assign o_zero = (o_result == '0);

endmodule

// File: rtl/cpu_ex_stage.sv
// MIPS execute stage: ID/EX register, ALU and branch-target adder, EX/MEM register.
module cpu_ex_stage
  import cpu_ex_stage_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             hold,
  input  logic [WIDTH-1:0] pc_4,
  input  logic [1:0]       wb,
  input  logic [2:0]       mem,
  input  logic [1:0]       aluop,
  input  logic             alusrc,
  input  logic             regdst,
  input  logic [WIDTH-1:0] rs,
  input  logic [WIDTH-1:0] rt,
  input  logic [WIDTH-1:0] signExt,
  input  logic [4:0]       instr20_16,
  input  logic [4:0]       instr15_11,
  output logic [1:0]       ex_mem_wb,
  output logic [2:0]       ex_mem_m,
  output logic [WIDTH-1:0] ex_mem_pc,
  output logic             ex_mem_zero,
  output logic [WIDTH-1:0] ex_mem_alu_result,
  output logic [WIDTH-1:0] ex_mem_rdata2,
  output logic [4:0]       ex_mem_dest
);

  id_ex_t      r_id_ex;
  ex_mem_t     r_ex_mem;
  id_ex_t      w_id_ex_next;
  ex_mem_t     w_ex_mem_next;
  logic [31:0] w_alu_b;
  logic [31:0] w_alu_result;
  logic        w_alu_zero;
  logic [31:0] w_branch_target;
  logic [4:0]  w_dest;

  // A flushed instruction still loads its data; only its control fields are killed.
  always_comb begin
    w_id_ex_next = {pc_4, wb, mem, aluop, alusrc, regdst, rs, rt, signExt, instr20_16, instr15_11};
    if (flush) begin
      w_id_ex_next.wb  = '0;
      w_id_ex_next.mem = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_id_ex <= '0;
    end else if (flush || !hold) begin
      r_id_ex <= w_id_ex_next;
    end
  end

  assign w_alu_b         = r_id_ex.alusrc ? r_id_ex.sign_ext : r_id_ex.rt;
  assign w_branch_target = r_id_ex.pc_4 + {r_id_ex.sign_ext[29:0], 2'b00};
  assign w_dest          = r_id_ex.regdst ? r_id_ex.rd_addr : r_id_ex.rt_addr;

  alu_unit u_alu (
    .i_aluop  (r_id_ex.aluop),
    .i_funct  (r_id_ex.sign_ext[5:0]),
    .i_a      (r_id_ex.rs),
    .i_b      (w_alu_b),
    .o_result (w_alu_result),
    .o_zero   (w_alu_zero)
  );

  always_comb begin
    w_ex_mem_next = '{
      wb:         r_id_ex.wb,
      mem:        r_id_ex.mem,
      pc:         w_branch_target,
      zero:       w_alu_zero,
      alu_result: w_alu_result,
      rdata2:     r_id_ex.rt,
      dest:       w_dest
    };
    if (flush || hold) begin
      w_ex_mem_next.wb  = '0;
      w_ex_mem_next.mem = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ex_mem <= '0;
    end else begin
      r_ex_mem <= w_ex_mem_next;
    end
  end

  assign ex_mem_wb         = r_ex_mem.wb;
  assign ex_mem_m          = r_ex_mem.mem;
  assign ex_mem_pc         = r_ex_mem.pc;
  assign ex_mem_zero       = r_ex_mem.zero;
  assign ex_mem_alu_result = r_ex_mem.alu_result;
  assign ex_mem_rdata2     = r_ex_mem.rdata2;
  assign ex_mem_dest       = r_ex_mem.dest;

endmodule

// File: tb/tb_cpu_ex_stage.sv
// Randomized and directed checks of cpu_ex_stage against a transaction-level model.
module tb_cpu_ex_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        hold = 1'b0;
  logic [31:0] pc_4 = '0;
  logic [1:0]  wb = '0;
  logic [2:0]  mem = '0;
  logic [1:0]  aluop = '0;
  logic        alusrc = 1'b0;
  logic        regdst = 1'b0;
  logic [31:0] rs = '0;
  logic [31:0] rt = '0;
  logic [31:0] signExt = '0;
  logic [4:0]  instr20_16 = '0;
  logic [4:0]  instr15_11 = '0;
  logic [1:0]  ex_mem_wb;
  logic [2:0]  ex_mem_m;
  logic [31:0] ex_mem_pc;
  logic        ex_mem_zero;
  logic [31:0] ex_mem_alu_result;
  logic [31:0] ex_mem_rdata2;
  logic [4:0]  ex_mem_dest;

  cpu_ex_stage #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .flush(flush), .hold(hold),
    .pc_4(pc_4), .wb(wb), .mem(mem), .aluop(aluop), .alusrc(alusrc), .regdst(regdst),
    .rs(rs), .rt(rt), .signExt(signExt), .instr20_16(instr20_16), .instr15_11(instr15_11),
    .ex_mem_wb(ex_mem_wb), .ex_mem_m(ex_mem_m), .ex_mem_pc(ex_mem_pc),
    .ex_mem_zero(ex_mem_zero), .ex_mem_alu_result(ex_mem_alu_result),
    .ex_mem_rdata2(ex_mem_rdata2), .ex_mem_dest(ex_mem_dest)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc_4;
    logic [1:0]  wb;
    logic [2:0]  mem;
    logic [1:0]  aluop;
    logic        alusrc;
    logic        regdst;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] se;
    logic [4:0]  i20;
    logic [4:0]  i15;
  } tx_t;

  typedef struct packed {
    logic [1:0]  wb;
    logic [2:0]  m;
    logic [31:0] pc;
    logic        zero;
    logic [31:0] res;
    logic [31:0] rd2;
    logic [4:0]  dest;
    logic        bub;
  } exp_t;

  int   total = 0;
  int   bad = 0;
  int   n_tx = 0;
  tx_t  m_idex;
  logic m_dc;
  exp_t m_out;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    if (obs !== exp_v) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp_v);
    end
  endtask

  // What the instruction should produce, straight from the ISA rules.
  function automatic exp_t ref_ex(input tx_t t);
    exp_t        e;
    logic [31:0] b;
    logic [31:0] r;
    b = t.alusrc ? t.se : t.rt;
    case (t.aluop)
      2'd0: r = t.rs + b;
      2'd1: r = t.rs - b;
      2'd3: r = ($signed(t.rs) < $signed(b)) ? 32'd1 : 32'd0;
      default: begin
        case (t.se[5:0])
          6'h20:   r = t.rs + b;
          6'h22:   r = t.rs - b;
          6'h24:   r = t.rs & b;
          6'h25:   r = t.rs | b;
          6'h27:   r = ~(t.rs | b);
          6'h2a:   r = ($signed(t.rs) < $signed(b)) ? 32'd1 : 32'd0;
          default: r = 32'd0;
        endcase
      end
    endcase
    e.wb   = t.wb;
    e.m    = t.mem;
    e.pc   = t.pc_4 + (t.se << 2);
    e.res  = r;
    e.zero = (r == 32'd0);
    e.rd2  = t.rt;
    e.dest = t.regdst ? t.i15 : t.i20;
    e.bub  = 1'b0;
    return e;
  endfunction

  function automatic tx_t rand_tx();
    tx_t         t;
    logic [31:0] r;
    logic [5:0]  f;
    t.pc_4   = $urandom;
    t.wb     = 2'($urandom_range(0, 3));
    t.mem    = 3'($urandom_range(0, 7));
    t.aluop  = 2'($urandom_range(0, 3));
    t.alusrc = 1'($urandom_range(0, 1));
    t.regdst = 1'($urandom_range(0, 1));
    t.rs     = $urandom;
    t.rt     = ($urandom_range(0, 3) == 0) ? t.rs : $urandom;
    t.i20    = 5'($urandom_range(0, 31));
    t.i15    = 5'($urandom_range(0, 31));
    r        = $urandom;
    case ($urandom_range(0, 6))
      0:       f = 6'h20;
      1:       f = 6'h22;
      2:       f = 6'h24;
      3:       f = 6'h25;
      4:       f = 6'h27;
      5:       f = 6'h2a;
      default: f = 6'($urandom_range(0, 63));
    endcase
    t.se = (t.aluop == 2'd2) ? {r[31:6], f} : r;
    return t;
  endfunction

  task automatic model_reset();
    m_idex = '0;
    m_dc   = 1'b1;
  endtask

  task automatic check_out();
    chk("wb", 32'(ex_mem_wb), 32'(m_out.wb));
    chk("m", 32'(ex_mem_m), 32'(m_out.m));
    if (!m_out.bub) begin
      chk("pc", ex_mem_pc, m_out.pc);
      chk("zero", 32'(ex_mem_zero), 32'(m_out.zero));
      chk("res", ex_mem_alu_result, m_out.res);
      chk("rdata2", ex_mem_rdata2, m_out.rd2);
      chk("dest", 32'(ex_mem_dest), 32'(m_out.dest));
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_wb"}, 32'(ex_mem_wb), 32'd0);
    chk({tag, "_m"}, 32'(ex_mem_m), 32'd0);
    chk({tag, "_pc"}, ex_mem_pc, 32'd0);
    chk({tag, "_zero"}, 32'(ex_mem_zero), 32'd0);
    chk({tag, "_res"}, ex_mem_alu_result, 32'd0);
    chk({tag, "_rdata2"}, ex_mem_rdata2, 32'd0);
    chk({tag, "_dest"}, 32'(ex_mem_dest), 32'd0);
  endtask

  // Called between edges; applies one instruction, takes one edge, checks, returns at negedge.
  task automatic drive(input tx_t t, input logic fl, input logic hd);
    pc_4 = t.pc_4; wb = t.wb; mem = t.mem; aluop = t.aluop; alusrc = t.alusrc;
    regdst = t.regdst; rs = t.rs; rt = t.rt; signExt = t.se;
    instr20_16 = t.i20; instr15_11 = t.i15;
    flush = fl; hold = hd;
    @(posedge clk);
    m_out = ref_ex(m_idex);
    if (fl || hd || m_dc) begin
      m_out.wb  = '0;
      m_out.m   = '0;
      m_out.bub = 1'b1;
    end
    if (fl) begin
      m_idex = t;
      m_dc   = 1'b1;
    end else if (!hd) begin
      m_idex = t;
      m_dc   = 1'b0;
    end
    #1;
    check_out();
    n_tx++;
    $display("tx %0d flush=%0d hold=%0d aluop=%0d -> wb=%0d m=%0d pc=%08h res=%08h dest=%0d",
             n_tx, fl, hd, t.aluop, ex_mem_wb, ex_mem_m, ex_mem_pc, ex_mem_alu_result, ex_mem_dest);
    @(negedge clk);
  endtask

  tx_t t_add, t_nop, t_x;

  initial begin
    t_nop = '0;
    model_reset();
    m_out = '0;

    // Reset from power-up, checked before any clock edge.
    #1 rst = 1'b1;
    #1 check_all_zero("rst_init");
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    // R-type add.
    t_add = '0;
    t_add.aluop = 2'b10; t_add.se = 32'h20; t_add.rs = 32'd5; t_add.rt = 32'd7;
    t_add.regdst = 1'b1; t_add.i15 = 5'd3; t_add.wb = 2'b10;
    drive(t_add, 1'b0, 1'b0);
    drive(t_nop, 1'b0, 1'b0);
    chk("add_res", ex_mem_alu_result, 32'd12);
    chk("add_dest", 32'(ex_mem_dest), 32'd3);
    chk("add_zero", 32'(ex_mem_zero), 32'd0);
    chk("add_wb", 32'(ex_mem_wb), 32'd2);

    // beq taken.
    t_x = '0;
    t_x.aluop = 2'b01; t_x.rs = 32'h10; t_x.rt = 32'h10; t_x.mem = 3'b100;
    t_x.pc_4 = 32'h40; t_x.se = 32'hFFFF_FFFE;
    drive(t_x, 1'b0, 1'b0);
    drive(t_nop, 1'b0, 1'b0);
    chk("beq_pc", ex_mem_pc, 32'h38);
    chk("beq_zero", 32'(ex_mem_zero), 32'd1);
    chk("beq_m", 32'(ex_mem_m), 32'd4);

    // lw address.
    t_x = '0;
    t_x.aluop = 2'b00; t_x.alusrc = 1'b1; t_x.rs = 32'h100; t_x.se = 32'hFFFF_FFFC;
    t_x.regdst = 1'b0; t_x.i20 = 5'd9; t_x.i15 = 5'd17;
    drive(t_x, 1'b0, 1'b0);
    drive(t_nop, 1'b0, 1'b0);
    chk("lw_res", ex_mem_alu_result, 32'hFC);
    chk("lw_dest", 32'(ex_mem_dest), 32'd9);

    // Signed SLT.
    t_x = '0;
    t_x.aluop = 2'b10; t_x.se = 32'h2a; t_x.rs = 32'hFFFF_FFFF; t_x.rt = 32'd1;
    drive(t_x, 1'b0, 1'b0);
    drive(t_nop, 1'b0, 1'b0);
    chk("slt_res", ex_mem_alu_result, 32'd1);

    // ADD wrap and branch-target wrap.
    t_x = '0;
    t_x.aluop = 2'b00; t_x.rs = 32'hFFFF_FFFF; t_x.rt = 32'd1;
    t_x.pc_4 = 32'hFFFF_FFFC; t_x.se = 32'd1;
    drive(t_x, 1'b0, 1'b0);
    drive(t_nop, 1'b0, 1'b0);
    chk("wrap_res", ex_mem_alu_result, 32'd0);
    chk("wrap_zero", 32'(ex_mem_zero), 32'd1);
    chk("wrap_pc", ex_mem_pc, 32'd0);

    // Two hold cycles on add: two bubbles, then add emerges.
    drive(t_add, 1'b0, 1'b0);
    drive(rand_tx(), 1'b0, 1'b1);
    chk("hold1_wb", 32'(ex_mem_wb), 32'd0);
    chk("hold1_m", 32'(ex_mem_m), 32'd0);
    drive(rand_tx(), 1'b0, 1'b1);
    chk("hold2_wb", 32'(ex_mem_wb), 32'd0);
    chk("hold2_m", 32'(ex_mem_m), 32'd0);
    drive(t_nop, 1'b0, 1'b0);
    chk("hold_add_res", ex_mem_alu_result, 32'd12);
    chk("hold_add_wb", 32'(ex_mem_wb), 32'd2);
    chk("hold_add_dest", 32'(ex_mem_dest), 32'd3);

    // flush+hold: both stages bubble, then the next instruction is captured.
    drive(t_add, 1'b0, 1'b0);
    t_x = rand_tx();
    t_x.wb = 2'b11;
    drive(t_x, 1'b1, 1'b1);
    chk("fh_wb", 32'(ex_mem_wb), 32'd0);
    drive(t_add, 1'b0, 1'b0);
    chk("fh_next_wb", 32'(ex_mem_wb), 32'd0);
    chk("fh_next_m", 32'(ex_mem_m), 32'd0);
    drive(t_nop, 1'b0, 1'b0);
    chk("fh_add_wb", 32'(ex_mem_wb), 32'd2);
    chk("fh_add_res", ex_mem_alu_result, 32'd12);

    // Random traffic.
    for (int i = 0; i < 300; i++) begin
      drive(rand_tx(), ($urandom_range(0, 9) == 0), ($urandom_range(0, 7) == 0));
    end

    // Asynchronous reset between edges with instructions in flight.
    t_x = rand_tx();
    t_x.wb = 2'b11; t_x.mem = 3'b111; t_x.pc_4 = 32'h1234_5678;
    drive(t_x, 1'b0, 1'b0);
    drive(rand_tx(), 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1 check_all_zero("rst_mid");
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    for (int i = 0; i < 100; i++) begin
      drive(rand_tx(), ($urandom_range(0, 9) == 0), ($urandom_range(0, 7) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
